pulse_event_pacer: RTL

- Source-domain front end for the pulse handshake synchronizer: accepts bursts of single-cycle event pulses and queues them as a pending count.
- Re-issues the events as single-cycle strobes spaced at least GAP_CYCLES apart, so none fall inside the synchronizer's req/ack round trip, where they would be lost.
- Sits in the input clock domain; o_pulse drives the synchronizer's i_in_pulse directly.

---
 rtl/pulse_event_pacer_pkg.sv | 26 ++
 rtl/pulse_event_pacer_sat_updown_counter.sv | 58 +++++
 rtl/pulse_event_pacer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pulse_event_pacer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_event_pacer_pkg
// Shared definitions for the pulse event pacer:
//   - state_t : pacer FSM encoding (IDLE waits for work, HOLD enforces spacing)
//   - clog2_f : ceiling log2, used to size the gap timer from GAP_CYCLES
// -----------------------------------------------------------------------------
package pulse_event_pacer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Number of bits needed to hold values 0 .. value-1 (returns 0 for value<=1).
   function automatic int clog2_f(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pulse_event_pacer_sat_updown_counter.sv
// -----------------------------------------------------------------------------
// sat_updown_counter
// Saturating up/down counter holding the number of queued events.
//
// Ports:
//   i_clk      : clock
//   i_rst_n    : synchronous active-low reset, clears the count
//   i_inc      : add one event
//   i_dec      : remove one event (ignored when the count is already zero)
//   i_clr      : synchronous clear; wins over i_inc and i_dec
//   o_count    : current count, registered
//   o_sat_drop : combinational flag, an increment is being dropped this cycle
//                because the count is at its maximum and nothing is leaving
// -----------------------------------------------------------------------------
module sat_updown_counter #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_sat_drop
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_count;
   logic             w_full;
   logic             w_empty;

   assign w_full  = (r_count == CNT_MAX);
   assign w_empty = (r_count == '0);

   // Simultaneous inc and dec cancel, so a full counter accepts a new event
   // on the same edge one leaves.
   assign o_sat_drop = i_inc && !i_dec && !i_clr && w_full;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_dec) begin
         if (!w_full) begin
            r_count <= r_count + 1'b1;
         end
      end else if (i_dec && !i_inc) begin
         if (!w_empty) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pulse_event_pacer.sv
// -----------------------------------------------------------------------------
// pulse_event_pacer
// Source-domain front end for a pulse handshake synchronizer. Incoming event
// pulses are queued as a pending count and re-issued as single-cycle strobes
// spaced at least GAP_CYCLES apart, so no strobe lands inside the
// synchronizer's req/ack round trip.
//
// Ports:
//   i_clk      : source-domain clock
//   i_rst_n    : synchronous active-low reset
//   i_pulse    : event strobe, one event per high cycle
//   i_clr      : synchronous clear of pending count and overflow flag
//   o_pulse    : paced single-cycle strobe, registered
//   o_pending  : events queued but not yet emitted
//   o_empty    : o_pending == 0
//   o_busy     : spacing timer running (FSM in HOLD)
//   o_overflow : sticky, an event was dropped at saturation
// -----------------------------------------------------------------------------
module pulse_event_pacer
   import pulse_event_pacer_pkg::*;
#(
   parameter int CNT_WIDTH  = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_pulse,
   input  logic                 i_clr,
   output logic                 o_pulse,
   output logic [CNT_WIDTH-1:0] o_pending,
   output logic                 o_empty,
   output logic                 o_busy,
   output logic                 o_overflow
);

   localparam int TMR_W_RAW = clog2_f(GAP_CYCLES);
   localparam int TMR_W     = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(GAP_CYCLES - 1);

   generate
      if (GAP_CYCLES < 2) begin : g_bad_gap
         $error("pulse_event_pacer: GAP_CYCLES must be >= 2");
      end
      if (CNT_WIDTH < 1) begin : g_bad_width
         $error("pulse_event_pacer: CNT_WIDTH must be >= 1");
      end
   endgenerate

   state_t               r_state;
   logic [TMR_W-1:0]     r_timer;
   logic                 r_pulse;
   logic                 r_overflow;
   logic [CNT_WIDTH-1:0] w_pending;
   logic                 w_sat_drop;
   logic                 w_has_work;
   logic                 w_emit;

   // A clear on the same edge suppresses emission: the queue it would drain
   // from is being discarded.
   assign w_has_work = (w_pending != '0) && !i_clr;

   // IDLE emits as soon as work exists; HOLD only once the gap has expired.
   assign w_emit = w_has_work && ((r_state == ST_IDLE) || (r_timer == '0));

   sat_updown_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_pending (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_inc      (i_pulse),
      .i_dec      (w_emit),
      .i_clr      (i_clr),
      .o_count    (w_pending),
      .o_sat_drop (w_sat_drop)
   );

   // Pacing FSM and gap timer. The timer is reloaded with GAP_CYCLES-1 on each
   // emission and reaches zero exactly GAP_CYCLES-1 edges later, so the next
   // emission edge is GAP_CYCLES after the previous one. i_clr never touches
   // the state or timer, so an in-flight spacing window always completes.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= w_emit;
         case (r_state)
            ST_IDLE: begin
               if (w_emit) begin
                  r_timer <= TMR_RELOAD;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (r_timer != '0) begin
                  r_timer <= r_timer - 1'b1;
               end else if (w_emit) begin
                  r_timer <= TMR_RELOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_timer <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
      end else if (i_clr) begin
         r_overflow <= 1'b0;
      end else if (w_sat_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_pulse    = r_pulse;
   assign o_pending  = w_pending;
   assign o_empty    = (w_pending == '0);
   assign o_busy     = (r_state == ST_HOLD);
   assign o_overflow = r_overflow;

endmodule
